// File: rtl/boot_loader.sv
// Byte-stream program loader: parses a framed image, writes little-endian words
// into instruction memory and releases the CPU once the frame checksum matches.
module boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int unsigned MAX_WORDS = 1024,
    parameter logic [7:0]  HDR_BYTE  = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_reset,
    output logic [31:0] pc_start,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    state_t      state;
    logic [15:0] len;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;
    logic [7:0]  csum;

    logic        accept;
    logic [15:0] len_rx;

    assign accept   = rx_valid && rx_ready;
    assign len_rx   = {rx_data, len[7:0]};
    assign pc_start = BASE_ADDR;

    // NOTE: the reset is synchronous, so it lives inside the clocked block and
    // is only seen on a rising edge; it still overrides everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            len        <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
            csum       <= '0;
            rx_ready   <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= BASE_ADDR;
            mem_wdata  <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
        end else begin
            // NOTE: non-blocking assignments everywhere here, so every branch
            // reads the pre-edge value of each register regardless of order.
            mem_we <= 1'b0;

            if (accept) begin
                case (state)
                    // A header restarts a frame from idle or after a rejection.
                    S_IDLE, S_ERROR: begin
                        if (rx_data == HDR_BYTE) begin
                            state      <= S_LEN_LO;
                            word_count <= '0;
                            csum       <= '0;
                            byte_idx   <= '0;
                            error      <= 1'b0;
                        end
                    end

                    S_LEN_LO: begin
                        len   <= {8'd0, rx_data};
                        state <= S_LEN_HI;
                    end

                    S_LEN_HI: begin
                        len <= len_rx;
                        if (len_rx == 16'd0 || len_rx > MAX_LEN) begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end

                    // Bytes enter at the top of word_buf, so after three of them
                    // the first byte sits in bits [7:0] and the word is complete
                    // once the fourth byte is placed above them.
                    S_DATA: begin
                        csum     <= csum ^ rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            mem_we     <= 1'b1;
                            mem_wdata  <= {rx_data, word_buf};
                            mem_addr   <= BASE_ADDR + {14'd0, word_count, 2'b00};
                            word_count <= word_count + 16'd1;
                            if (word_count == len - 16'd1) begin
                                state <= S_CSUM;
                            end
                        end else begin
                            word_buf <= {rx_data, word_buf[23:8]};
                        end
                    end

                    S_CSUM: begin
                        if (rx_data == csum) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                            rx_ready  <= 1'b0;
                        end else begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end
                    end

                    S_DONE: begin
                        state <= S_DONE;
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed frames plus randomized frames,
// compared byte by byte against a frame-position reference model.
module tb_boot_loader;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          MAXW = 1024;
    localparam logic [7:0]  HDR  = 8'hA5;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic [31:0] pc_start;
    logic        done;
    logic        error;
    logic [15:0] word_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    boot_loader #(
        .BASE_ADDR(BASE),
        .MAX_WORDS(MAXW),
        .HDR_BYTE (HDR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .pc_start  (pc_start),
        .done      (done),
        .error     (error),
        .word_count(word_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: position within the frame (-1 while hunting for a header)
    int          m_pos;
    int          m_len;
    int          m_wc;
    bit          m_done;
    bit          m_error;
    logic [7:0]  m_x;
    logic [7:0]  m_q[$];
    logic [63:0] exp_wr[$];

    task automatic model_reset();
        m_pos   = -1;
        m_len   = 0;
        m_wc    = 0;
        m_done  = 1'b0;
        m_error = 1'b0;
        m_x     = 8'd0;
        m_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_done) return;
        if (m_pos < 0) begin
            if (b == HDR) begin
                m_pos   = 1;
                m_wc    = 0;
                m_x     = 8'd0;
                m_error = 1'b0;
                m_q.delete();
            end
            return;
        end
        if (m_pos == 1) begin
            m_len = int'(b);
        end else if (m_pos == 2) begin
            m_len = m_len + 256 * int'(b);
            if (m_len == 0 || m_len > MAXW) begin
                m_error = 1'b1;
                m_pos   = -1;
                return;
            end
        end else if (m_pos < 3 + 4 * m_len) begin
            m_q.push_back(b);
            m_x = m_x ^ b;
            if (m_q.size() == 4) begin
                exp_wr.push_back({BASE + 32'(4 * m_wc), m_q[3], m_q[2], m_q[1], m_q[0]});
                m_wc++;
                m_q.delete();
            end
        end else begin
            if (b == m_x) m_done = 1'b1;
            else          m_error = 1'b1;
            m_pos = -1;
            return;
        end
        m_pos++;
    endtask

    // Write monitor: every strobe must match the oldest expected write
    int          n_we = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_data = '0;
    logic [63:0] mon_e;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            n_we++;
            last_addr = mem_addr;
            last_data = mem_wdata;
            if (exp_wr.size() == 0) begin
                check("unexpected_we", 32'd1, 32'd0);
            end else begin
                mon_e = exp_wr.pop_front();
                check("we_addr", mem_addr, mon_e[63:32]);
                check("we_data", mem_wdata, mon_e[31:0]);
            end
        end
    end

    task automatic check_status(input string tag);
        check({tag, "_wc"},        32'(word_count), 32'(m_wc));
        check({tag, "_done"},      32'(done),       32'(m_done));
        check({tag, "_error"},     32'(error),      32'(m_error));
        check({tag, "_cpu_reset"}, 32'(cpu_reset),  32'(!m_done));
        check({tag, "_rx_ready"},  32'(rx_ready),   32'(!m_done));
    endtask

    // Offer one byte at a negedge; the model sees it only if the DUT takes it.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc;
        rx_valid = 1'b1;
        rx_data  = b;
        acc      = rx_ready;
        @(posedge clk);
        if (acc) model_byte(b);
        @(negedge clk);
        rx_valid = 1'b0;
        check_status("byte");
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_bytes(input logic [7:0] q[$], input int maxgap);
        foreach (q[i]) send_byte(q[i], int'($urandom_range(0, maxgap)));
    endtask

    task automatic send_frame(input int n, input bit bad, input int maxgap);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'd0;
        send_byte(HDR, int'($urandom_range(0, maxgap)));
        send_byte(8'(n), int'($urandom_range(0, maxgap)));
        send_byte(8'(n >> 8), int'($urandom_range(0, maxgap)));
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            x = x ^ b;
            send_byte(b, int'($urandom_range(0, maxgap)));
        end
        if (bad) x = x ^ 8'($urandom_range(1, 255));
        send_byte(x, int'($urandom_range(0, maxgap)));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("rst_rx_ready",   32'(rx_ready),   32'd1);
        check("rst_mem_we",     32'(mem_we),     32'd0);
        check("rst_mem_addr",   mem_addr,        BASE);
        check("rst_mem_wdata",  mem_wdata,       32'd0);
        check("rst_cpu_reset",  32'(cpu_reset),  32'd1);
        check("rst_done",       32'(done),       32'd0);
        check("rst_error",      32'(error),      32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    logic [7:0] good1[$];
    logic [7:0] bq[$];
    int         we0;
    logic [7:0] g;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        model_reset();
        good1 = {8'hA5, 8'h01, 8'h00, 8'hB3, 8'h04, 8'h5A, 8'h01, 8'hEC};

        // Single-word load, back-to-back bytes
        do_reset();
        we0 = n_we;
        send_bytes(good1, 0);
        settle();
        check("t1_we_count",  32'(n_we - we0),   32'd1);
        check("t1_addr",      last_addr,         32'h1000_0000);
        check("t1_data",      last_data,         32'h015A_04B3);
        check("t1_done",      32'(done),         32'd1);
        check("t1_cpu_reset", 32'(cpu_reset),    32'd0);
        check("t1_wc",        32'(word_count),   32'd1);
        check("t1_pc_start",  pc_start,          32'h1000_0000);
        // DONE refuses further bytes
        send_byte(HDR, 0);
        send_byte(8'h00, 0);
        check("t1_ready_after", 32'(rx_ready), 32'd0);
        check("t1_we_after",    32'(n_we - we0), 32'd1);

        // Two words with random stalls
        do_reset();
        we0 = n_we;
        bq = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h13};
        send_bytes(bq, 3);
        settle();
        check("t2_we_count", 32'(n_we - we0), 32'd2);
        check("t2_addr",     last_addr,       32'h1000_0004);
        check("t2_data",     last_data,       32'hFFFF_FFFF);
        check("t2_done",     32'(done),       32'd1);

        // Bad checksum, then the good frame
        do_reset();
        bq = good1;
        bq[7] = 8'h00;
        send_bytes(bq, 1);
        check("t3_error",     32'(error),     32'd1);
        check("t3_done",      32'(done),      32'd0);
        check("t3_cpu_reset", 32'(cpu_reset), 32'd1);
        send_byte(HDR, 0);
        check("t3_error_clr", 32'(error), 32'd0);
        bq = good1;
        bq.delete(0);
        send_bytes(bq, 0);
        check("t3_done_retry", 32'(done), 32'd1);

        // Length rejects: zero and MAX_WORDS+1
        do_reset();
        we0 = n_we;
        bq = {8'hA5, 8'h00, 8'h00};
        send_bytes(bq, 0);
        check("t4_len0_error", 32'(error), 32'd1);
        bq = {8'hA5, 8'h01, 8'h04};
        send_bytes(bq, 0);
        settle();
        check("t4_len1025_error", 32'(error), 32'd1);
        check("t4_no_writes",     32'(n_we - we0), 32'd0);

        // Garbage ahead of the header
        do_reset();
        we0 = n_we;
        bq = {8'h00, 8'hFF, 8'h5A};
        send_bytes(bq, 0);
        check("t5_garbage_wc", 32'(word_count), 32'd0);
        send_bytes(good1, 0);
        settle();
        check("t5_done",     32'(done),       32'd1);
        check("t5_we_count", 32'(n_we - we0), 32'd1);

        // Reset in the middle of DATA, then a clean reload
        do_reset();
        bq = {8'hA5, 8'h01, 8'h00, 8'hB3, 8'h04};
        send_bytes(bq, 0);
        do_reset();
        send_bytes(good1, 0);
        check("t6_done", 32'(done), 32'd1);

        // Largest legal payload
        do_reset();
        we0 = n_we;
        send_frame(MAXW, 1'b0, 0);
        settle();
        check("t7_wc",       32'(word_count),  32'(MAXW));
        check("t7_done",     32'(done),        32'd1);
        check("t7_we_count", 32'(n_we - we0),  32'(MAXW));

        // Randomized frames with garbage, stalls and occasional bad checksums
        for (int it = 0; it < 20; it++) begin
            do_reset();
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                g = 8'($urandom);
                if (g == HDR) g = 8'h00;
                send_byte(g, int'($urandom_range(0, 2)));
            end
            send_frame(int'($urandom_range(1, 6)), $urandom_range(0, 3) == 0, 3);
            if (!m_done) send_frame(int'($urandom_range(1, 6)), 1'b0, 2);
            settle();
            check("rand_done", 32'(done), 32'(m_done));
        end

        settle();
        check("pending_writes", 32'(exp_wr.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
